// File: rtl/pc_stack_unit.sv
// Program counter with absolute jump, relative branch, stall and a hardware
// call/return stack; drives the instruction-memory address.
module pc_stack_unit #(
    parameter int unsigned     SIZE      = 5,
    parameter int unsigned     OFF_W     = 4,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [SIZE-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             jmp,
    input  logic [SIZE-1:0]  jmp_addr,
    input  logic             br,
    input  logic [OFF_W-1:0] br_off,
    input  logic             call,
    input  logic             ret,
    output logic [SIZE-1:0]  pc_out,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             err
);

    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SIZE-1:0]  stack_mem [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_nxt;
    logic [SIZE-1:0]  pc_nxt;
    logic [SIZE-1:0]  pc_inc;
    logic [SIZE-1:0]  br_tgt;
    logic [SIZE-1:0]  top_entry;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             err_nxt;
    logic             push;
    logic             sp_is_empty;
    logic             sp_is_full;

    // All PC arithmetic is SIZE bits and wraps silently.
    assign pc_inc      = pc_out + SIZE'(1);
    assign br_tgt      = pc_out + SIZE'($signed(br_off));
    assign rd_idx      = IDX_W'(sp - SP_W'(1));
    assign wr_idx      = IDX_W'(sp);
    assign top_entry   = stack_mem[rd_idx];
    assign sp_is_empty = (sp == '0);
    assign sp_is_full  = (sp == SP_W'(DEPTH));

    // Next-state selection, priority ret > call > jmp > br > increment.
    always_comb begin
        pc_nxt  = pc_out;
        sp_nxt  = sp;
        err_nxt = err;
        push    = 1'b0;
        if (en) begin
            if (ret) begin
                if (!sp_is_empty) begin
                    pc_nxt = top_entry;
                    sp_nxt = sp - SP_W'(1);
                end else begin
                    err_nxt = 1'b1;
                    pc_nxt  = pc_inc;
                end
            end else if (call) begin
                if (!sp_is_full) begin
                    push   = 1'b1;
                    sp_nxt = sp + SP_W'(1);
                    pc_nxt = jmp_addr;
                end else begin
                    err_nxt = 1'b1;
                    pc_nxt  = pc_inc;
                end
            end else if (jmp) begin
                pc_nxt = jmp_addr;
            end else if (br) begin
                pc_nxt = br_tgt;
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    // Control state; flags are registered from the next stack pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out    <= RESET_VEC;
            sp        <= '0;
            err       <= 1'b0;
            stk_empty <= 1'b1;
            stk_full  <= 1'b0;
        end else begin
            pc_out    <= pc_nxt;
            sp        <= sp_nxt;
            err       <= err_nxt;
            stk_empty <= (sp_nxt == '0);
            stk_full  <= (sp_nxt == SP_W'(DEPTH));
        end
    end

    // Return-address storage is not reset; a reset edge discards a pending push.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed vector table, hand sequences
// and randomized stimulus against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int SIZE  = 5;
    localparam int OFF_W = 4;
    localparam int DEPTH = 4;
    localparam int RV    = 0;
    localparam int MODN  = 32;

    logic             clk;
    logic             rst;
    logic             en;
    logic             jmp;
    logic [SIZE-1:0]  jmp_addr;
    logic             br;
    logic [OFF_W-1:0] br_off;
    logic             call;
    logic             ret;
    logic [SIZE-1:0]  pc_out;
    logic             stk_empty;
    logic             stk_full;
    logic             err;

    int checks   = 0;
    int failures = 0;

    pc_stack_unit #(
        .SIZE(SIZE), .OFF_W(OFF_W), .DEPTH(DEPTH), .RESET_VEC(5'(RV))
    ) dut (
        .clk(clk), .rst(rst), .en(en), .jmp(jmp), .jmp_addr(jmp_addr),
        .br(br), .br_off(br_off), .call(call), .ret(ret),
        .pc_out(pc_out), .stk_empty(stk_empty), .stk_full(stk_full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, jmp;
        logic [4:0] ja;
        logic       br;
        logic [3:0] bo;
        logic       call, ret;
        logic [4:0] epc;
        logic       eemp, efull, eerr;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int mpc;
    int mq[$];
    bit merr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic j, input logic [4:0] ja,
                         input logic b, input logic [3:0] bo, input logic c, input logic rt);
        rst = r; en = e; jmp = j; jmp_addr = ja; br = b; br_off = bo; call = c; ret = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic j, input logic [4:0] ja,
                       input logic b, input logic [3:0] bo, input logic c, input logic rt,
                       input logic [4:0] epc, input logic eemp, input logic efull, input logic eerr);
        vec_t v;
        v.rst = r; v.en = e; v.jmp = j; v.ja = ja; v.br = b; v.bo = bo; v.call = c; v.ret = rt;
        v.epc = epc; v.eemp = eemp; v.efull = efull; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic model_step(input logic r, input logic e, input logic j, input logic [4:0] ja,
                              input logic b, input logic [3:0] bo, input logic c, input logic rt);
        if (r) begin
            mpc = RV; mq.delete(); merr = 1'b0;
        end else if (e) begin
            if (rt) begin
                if (mq.size() > 0) mpc = mq.pop_back();
                else begin merr = 1'b1; mpc = (mpc + 1) % MODN; end
            end else if (c) begin
                if (mq.size() == DEPTH) begin merr = 1'b1; mpc = (mpc + 1) % MODN; end
                else begin mq.push_back((mpc + 1) % MODN); mpc = int'(ja); end
            end else if (j) begin
                mpc = int'(ja);
            end else if (b) begin
                mpc = (((mpc + int'($signed(bo))) % MODN) + MODN) % MODN;
            end else begin
                mpc = (mpc + 1) % MODN;
            end
        end
    endtask

    initial begin
        logic r, e, j, b, c, rt;
        logic [4:0] ja;
        logic [3:0] bo;

        rst = 1'b0; en = 1'b0; jmp = 1'b0; jmp_addr = '0; br = 1'b0; br_off = '0;
        call = 1'b0; ret = 1'b0;
        #2;

        // Reset state
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_pc", 32'(pc_out), 32'(RV));
        chk("reset_empty", 32'(stk_empty), 1);
        chk("reset_full", 32'(stk_full), 0);
        chk("reset_err", 32'(err), 0);

        // Free run 33 cycles, wrapping through 31 -> 0
        for (int i = 1; i <= 33; i++) begin
            apply(0, 1, 0, 0, 0, 0, 0, 0);
            chk($sformatf("free_run_%0d", i), 32'(pc_out), 32'(i % MODN));
        end
        chk("free_run_err", 32'(err), 0);

        //   rst en jmp ja  br bo      call ret  pc  emp full err
        add(0, 1, 1, 7,  0, 0,       0, 0,   7,  1, 0, 0);
        add(0, 0, 1, 20, 0, 0,       0, 0,   7,  1, 0, 0);
        add(0, 1, 1, 20, 0, 0,       0, 0,   20, 1, 0, 0);
        add(0, 1, 0, 0,  1, 4'b1100, 0, 0,   16, 1, 0, 0);
        add(0, 1, 1, 30, 0, 0,       0, 0,   30, 1, 0, 0);
        add(0, 1, 0, 0,  1, 4'b0111, 0, 0,   5,  1, 0, 0);
        add(0, 1, 1, 17, 1, 4'b0011, 0, 0,   17, 1, 0, 0);
        add(0, 1, 0, 0,  1, 4'b0000, 0, 0,   17, 1, 0, 0);
        add(0, 1, 0, 0,  1, 4'b1000, 0, 0,   9,  1, 0, 0);
        // nested call/return
        add(0, 1, 1, 3,  0, 0,       0, 0,   3,  1, 0, 0);
        add(0, 1, 0, 10, 0, 0,       1, 0,   10, 0, 0, 0);
        add(0, 1, 1, 12, 0, 0,       0, 0,   12, 0, 0, 0);
        add(0, 1, 0, 25, 0, 0,       1, 0,   25, 0, 0, 0);
        add(0, 1, 0, 0,  0, 0,       0, 1,   13, 0, 0, 0);
        add(0, 1, 0, 0,  0, 0,       0, 1,   4,  1, 0, 0);
        // overflow
        add(0, 1, 1, 0,  0, 0,       0, 0,   0,  1, 0, 0);
        add(0, 1, 0, 8,  0, 0,       1, 0,   8,  0, 0, 0);
        add(0, 1, 0, 8,  0, 0,       1, 0,   8,  0, 0, 0);
        add(0, 1, 0, 8,  0, 0,       1, 0,   8,  0, 0, 0);
        add(0, 1, 0, 8,  0, 0,       1, 0,   8,  0, 1, 0);
        add(0, 1, 0, 8,  0, 0,       1, 0,   9,  0, 1, 1);
        add(0, 1, 0, 0,  0, 0,       0, 1,   9,  0, 0, 1);
        add(0, 1, 0, 0,  0, 0,       0, 1,   9,  0, 0, 1);
        add(0, 1, 0, 0,  0, 0,       0, 1,   9,  0, 0, 1);
        add(0, 1, 0, 0,  0, 0,       0, 1,   1,  1, 0, 1);
        // underflow and priority
        add(1, 1, 0, 0,  0, 0,       0, 0,   0,  1, 0, 0);
        add(0, 1, 1, 5,  0, 0,       0, 0,   5,  1, 0, 0);
        add(0, 1, 1, 9,  0, 0,       1, 1,   6,  1, 0, 1);
        add(0, 1, 1, 2,  0, 0,       1, 0,   2,  0, 0, 1);
        add(0, 1, 0, 13, 0, 0,       1, 0,   13, 0, 0, 1);
        add(0, 1, 0, 0,  0, 0,       0, 0,   14, 0, 0, 1);
        add(0, 1, 0, 0,  0, 0,       0, 1,   3,  0, 0, 1);
        add(0, 1, 0, 0,  0, 0,       0, 1,   7,  1, 0, 1);
        // reset together with call discards the push
        add(0, 1, 0, 14, 0, 0,       1, 0,   14, 0, 0, 1);
        add(0, 1, 0, 14, 0, 0,       1, 0,   14, 0, 0, 1);
        add(1, 1, 0, 20, 0, 0,       1, 0,   0,  1, 0, 0);
        add(0, 1, 0, 0,  0, 0,       0, 1,   1,  1, 0, 1);

        foreach (vecs[k]) begin
            apply(vecs[k].rst, vecs[k].en, vecs[k].jmp, vecs[k].ja, vecs[k].br,
                  vecs[k].bo, vecs[k].call, vecs[k].ret);
            chk($sformatf("vec%0d_pc", k), 32'(pc_out), 32'(vecs[k].epc));
            chk($sformatf("vec%0d_empty", k), 32'(stk_empty), 32'(vecs[k].eemp));
            chk($sformatf("vec%0d_full", k), 32'(stk_full), 32'(vecs[k].efull));
            chk($sformatf("vec%0d_err", k), 32'(err), 32'(vecs[k].eerr));
        end

        // A reset pulse between edges has no effect
        rst = 1'b0; en = 1'b1; jmp = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("glitch_rst_pc", 32'(pc_out), 2);
        chk("glitch_rst_err", 32'(err), 1);

        // Randomized phase against the reference model
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 7) != 0);
            j  = ($urandom_range(0, 3) == 0);
            ja = 5'($urandom);
            b  = ($urandom_range(0, 2) == 0);
            bo = 4'($urandom);
            c  = ($urandom_range(0, 2) == 0);
            rt = ($urandom_range(0, 4) == 0);
            apply(r, e, j, ja, b, bo, c, rt);
            model_step(r, e, j, ja, b, bo, c, rt);
            chk($sformatf("rand%0d_pc", i), 32'(pc_out), 32'(mpc));
            chk($sformatf("rand%0d_empty", i), 32'(stk_empty), 32'(mq.size() == 0));
            chk($sformatf("rand%0d_full", i), 32'(stk_full), 32'(mq.size() == DEPTH));
            chk($sformatf("rand%0d_err", i), 32'(err), 32'(merr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
